rssb_core_p: RTL and testbench
==============================

Name: rssb_core_p

Overview:
- Parametrised next-generation RSSB (reverse-subtract-and-skip-if-borrow) one-instruction processor core.
- Adds over the previous core: configurable data width, external memory behind a req/ack handshake with arbitrary wait states, a memory-mapped I/O location, start/halt control, and a retired-instruction counter.
- Sits between the system memory/IO fabric and the top level; it is the sole bus master.

Parameters:
- DATA_W, 8, width of accumulator, PC, instruction word and memory data; must be at least 4.
- HALT_ADDR, 2**DATA_W-1, instruction address whose fetch halts the core.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  pulse; leaves IDLE or HALTED and begins fetching at PC=0
- mem_req  output  1  memory request, held until acknowledged
- mem_we  output  1  1=write, 0=read; valid while mem_req=1
- mem_addr  output  DATA_W  memory address; valid while mem_req=1
- mem_wdata  output  DATA_W  write data; valid while mem_req=1 and mem_we=1
- mem_rdata  input  DATA_W  read data; sampled when mem_ack=1
- mem_ack  input  1  completes the current request; may be asserted in the same cycle as mem_req
- io_in  input  DATA_W  value returned when location 3 is read
- io_out  output  DATA_W  last value written to location 3
- io_valid  output  1  one-cycle pulse when io_out is updated
- update  output  1  one-cycle pulse when an instruction retires
- halted  output  1  high while in HALTED
- retired  output  CNT_W  count of retired instructions; wraps modulo 2**CNT_W

Behaviour:
- Reset values: all outputs 0; PC=0, A=0, state IDLE.
- Memory-mapped operand locations for instruction word a:
  - a=0: PC
  - a=1: A
  - a=2: constant zero (writes discarded)
  - a=3: read io_in, write io_out
  - a>=4: external memory
- Instruction semantics:
  - a = M[PC]
  - r = operand(a) - A, modulo 2**DATA_W
  - A <= r; destination(a) <= r
  - Borrow is r[DATA_W-1].
  - Next PC = base+1, or base+2 if borrow, where base is r when a=0 and the old PC otherwise. All PC arithmetic wraps modulo 2**DATA_W.
- States:
  - IDLE: wait for start. On start, PC<=0, A<=0, go to FETCH.
  - FETCH:
    - If PC==HALT_ADDR, go to HALTED without issuing a request.
    - Otherwise assert mem_req with we=0 and addr=PC. On ack, latch a from mem_rdata and go to OPERAND.
  - OPERAND:
    - a<4: no request; compute r, apply all updates and retire this cycle, go to FETCH.
    - a>=4: read request to addr=a. On ack, latch r into the result register, update A, go to WRITE.
  - WRITE: write request with addr=a and wdata=r. On ack, update PC, retire, go to FETCH.
  - HALTED: halted=1; start behaves as it does from IDLE.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable from assertion through the ack cycle.
  - mem_req deasserts the cycle after ack unless the next state issues a new request.
  - An ack while mem_req=0 is ignored.
- Latency with zero-wait memory (ack in the request cycle): 2 cycles for a<4, 3 cycles for a>=4. Each wait cycle adds 1.
- Retire effects:
  - update pulses for exactly one cycle.
  - retired increments on the same edge.
  - io_valid pulses with the update when a=3.
- Simultaneous events: when a=1, A takes r once; there is no double write. start is ignored outside IDLE/HALTED.
- Reset mid-transaction: any outstanding request is abandoned and mem_req drops asynchronously. Memory must tolerate a dropped request.

Decomposition:
- Package rssb_pkg: state enum {IDLE, FETCH, OPERAND, WRITE, HALTED}, and constants LOC_PC=0, LOC_ACC=1, LOC_ZERO=2, LOC_IO=3, FIRST_MEM=4.
- One sub-module, rssb_alu: combinational, parametrised by DATA_W; produces r and borrow from operand and A.
- Control FSM and datapath stay inside rssb_core_p.

Test Plan:
- Reset then start, memory always acks, M[0]=2 -> r=0-0=0, A=0, no skip, PC=1, update pulses once, retire at cycle 2.
- A=5, M[1]=10 and M[10]=3 -> r=0xFE, A=0xFE, M[10]<=0xFE, borrow so PC=3, retired+1, 3-cycle retire.
- Memory ack delayed 4 cycles on every request -> mem_req/addr/we/wdata held stable throughout; same architectural results as zero-wait.
- io_in=0x40, A=0x10, instruction a=3 -> A=0x30, io_out=0x30, io_valid one pulse coincident with update.
- Instruction a=0 with PC=6 and A=2 -> r=4, PC=5; instruction a=0 with A=0x80 -> PC=r+2.
- PC reaches HALT_ADDR -> no mem_req, halted=1; then assert start -> restart at PC=0. Assert reset during a WRITE wait -> mem_req=0 immediately, all outputs 0.

Source files
------------

// File: rtl/rssb_pkg.sv
// rssb_pkg: shared state encoding and operand location map for the RSSB core
package rssb_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, OPERAND, WRITE, HALTED} state_t;
    localparam int LOC_PC    = 0;
    localparam int LOC_ACC   = 1;
    localparam int LOC_ZERO  = 2;
    localparam int LOC_IO    = 3;
    localparam int FIRST_MEM = 4;
endpackage

// File: rtl/rssb_alu.sv
// rssb_alu: reverse subtract r = operand - acc, borrow taken from the result sign
module rssb_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] operand,
    input  logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] r,
    output logic              borrow
);
    assign r      = operand - acc;
    assign borrow = r[DATA_W-1];
endmodule

// File: rtl/rssb_core_p.sv
// rssb_core_p: parametrised RSSB one-instruction core, sole master of a req/ack memory bus
module rssb_core_p
    import rssb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int HALT_ADDR = 2**DATA_W-1,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              io_valid,
    output logic              update,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);
    localparam logic [DATA_W-1:0] HALT = DATA_W'(HALT_ADDR);
    state_t state, next_state;
    logic [DATA_W-1:0] pc, acc, ins, res, operand, r, base, npc_op, npc_wr;
    logic borrow, ack, is_mem, at_halt;
    assign ack     = mem_req & mem_ack;
    assign is_mem  = ins >= DATA_W'(FIRST_MEM);
    assign at_halt = pc == HALT;
    // In OPERAND with a memory operand the ALU consumes the read data directly
    always_comb
        operand = (ins == DATA_W'(LOC_PC))   ? pc :
                  (ins == DATA_W'(LOC_ACC))  ? acc :
                  (ins == DATA_W'(LOC_ZERO)) ? '0 :
                  (ins == DATA_W'(LOC_IO))   ? io_in : mem_rdata;
    rssb_alu #(.DATA_W(DATA_W)) alu (
        .operand(operand),
        .acc    (acc),
        .r      (r),
        .borrow (borrow)
    );
    assign base   = (ins == DATA_W'(LOC_PC)) ? r : pc;
    assign npc_op = base + DATA_W'(1) + DATA_W'(borrow);
    assign npc_wr = pc + DATA_W'(1) + DATA_W'(res[DATA_W-1]);
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= next_state;
    always_comb begin
        next_state = state;
        case (state)
            IDLE, HALTED: next_state = start ? FETCH : state;
            FETCH:        next_state = at_halt ? HALTED : ack ? OPERAND : FETCH;
            OPERAND:      next_state = !is_mem ? FETCH : ack ? WRITE : OPERAND;
            WRITE:        next_state = ack ? FETCH : WRITE;
            default:      next_state = IDLE;
        endcase
    end
    always_comb begin
        mem_req   = (state == FETCH && !at_halt) || (state == OPERAND && is_mem) || state == WRITE;
        mem_we    = state == WRITE;
        mem_addr  = (state == FETCH) ? pc : ins;
        mem_wdata = (state == WRITE) ? res : '0;
        halted    = state == HALTED;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc       <= '0;
            acc      <= '0;
            ins      <= '0;
            res      <= '0;
            io_out   <= '0;
            io_valid <= 1'b0;
            update   <= 1'b0;
            retired  <= '0;
        end else begin
            update   <= 1'b0;
            io_valid <= 1'b0;
            case (state)
                IDLE, HALTED: if (start) begin
                    pc  <= '0;
                    acc <= '0;
                end
                FETCH: if (ack) ins <= mem_rdata;
                OPERAND: if (!is_mem) begin
                    acc     <= r;
                    pc      <= npc_op;
                    update  <= 1'b1;
                    retired <= retired + CNT_W'(1);
                    if (ins == DATA_W'(LOC_IO)) begin
                        io_out   <= r;
                        io_valid <= 1'b1;
                    end
                end else if (ack) begin
                    res <= r;
                    acc <= r;
                end
                WRITE: if (ack) begin
                    pc      <= npc_wr;
                    update  <= 1'b1;
                    retired <= retired + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rssb_core_p.sv
// tb_rssb_core_p: vector table, directed corner sequences and ISA-level random checking
module tb_rssb_core_p;
    localparam int W = 8;
    logic clock = 0, reset = 0, start = 0, mem_ack = 0;
    logic mem_req, mem_we, io_valid, update, halted;
    logic [W-1:0] mem_addr, mem_wdata, io_out;
    logic [W-1:0] mem_rdata = '0, io_in = '0;
    logic [15:0] retired;
    always #5 clock = ~clock;
    rssb_core_p dut (
        .clock(clock), .reset(reset), .start(start),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .io_in(io_in), .io_out(io_out),
        .io_valid(io_valid), .update(update), .halted(halted), .retired(retired)
    );
    logic [W-1:0] mem [256];
    int tests = 0, fails = 0;
    int wait_n = 0, wcnt = 0, target = 0, upd_cnt = 0;
    bit rand_wait = 0, pending = 0, model_on = 0;
    logic hold_we;
    logic [W-1:0] hold_addr, hold_wdata;
    typedef struct {logic we; logic [W-1:0] addr; logic [W-1:0] data;} txn_t;
    txn_t exp_q[$];
    logic [W-1:0] io_q[$];
    logic [W-1:0] m_mem [256];
    logic [W-1:0] m_pc, m_acc;
    bit m_halt;
    typedef struct {logic [W-1:0] a, mval, io; int wt, lat; logic [W-1:0] npc, res; bit io_ev;} vec_t;
    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural model: executes one whole instruction and lists the bus traffic it implies
    task automatic model_step();
        logic [W-1:0] a, op, r;
        if (m_pc == 8'hFF) begin
            m_halt = 1;
            return;
        end
        a = m_mem[m_pc];
        exp_q.push_back('{1'b0, m_pc, '0});
        if (a < 4) begin
            op = (a == 0) ? m_pc : (a == 1) ? m_acc : (a == 2) ? 8'h00 : io_in;
            r = op - m_acc;
            m_acc = r;
            if (a == 3) io_q.push_back(r);
            m_pc = W'(int'((a == 0) ? r : m_pc) + (r[W-1] ? 2 : 1));
        end else begin
            r = m_mem[a] - m_acc;
            m_acc = r;
            exp_q.push_back('{1'b0, a, '0});
            exp_q.push_back('{1'b1, a, r});
            m_mem[a] = r;
            m_pc = W'(int'(m_pc) + (r[W-1] ? 2 : 1));
        end
    endtask

    task automatic check_txn();
        txn_t t;
        if (exp_q.size() == 0) model_step();
        if (exp_q.size() == 0) chk("txn_after_halt", 32'(mem_addr), 32'hFFFF_FFFF);
        else begin
            t = exp_q.pop_front();
            chk("txn_we", 32'(mem_we), 32'(t.we));
            chk("txn_addr", 32'(mem_addr), 32'(t.addr));
            if (t.we) chk("txn_wdata", 32'(mem_wdata), 32'(t.data));
        end
    endtask

    // One clock: observe at the falling edge, then act as memory for the next rising edge
    task automatic cyc();
        @(negedge clock);
        if (update) begin
            upd_cnt++;
            chk("retired", 32'(retired), 32'(upd_cnt));
        end
        if (model_on && io_valid) begin
            if (io_q.size() == 0) chk("io_unexpected", 32'(io_out), 32'hFFFF_FFFF);
            else chk("io_out_model", 32'(io_out), 32'(io_q.pop_front()));
        end
        if (mem_req) begin
            if (!pending) begin
                pending = 1;
                wcnt = 0;
                target = rand_wait ? int'($urandom_range(0, 3)) : wait_n;
                hold_we = mem_we;
                hold_addr = mem_addr;
                hold_wdata = mem_wdata;
            end else
                chk("req_stable", 32'({hold_we, hold_addr, hold_wdata}), 32'({mem_we, mem_addr, mem_wdata}));
            mem_rdata = mem[mem_addr];
            if (wcnt >= target) begin
                mem_ack = 1;
                pending = 0;
                if (mem_we) mem[mem_addr] = mem_wdata;
                if (model_on) check_txn();
            end else begin
                mem_ack = 0;
                wcnt++;
            end
        end else begin
            mem_ack = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            pending = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1;
        start = 0;
        mem_ack = 0;
        pending = 0;
        model_on = 0;
        rand_wait = 0;
        wait_n = 0;
        exp_q.delete();
        io_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (2) @(negedge clock);
        reset = 0;
        upd_cnt = 0;
    endtask

    task automatic go();
        start = 1;
        cyc();
        start = 0;
    endtask

    task automatic run_upd(input int n, input int budget);
        int s;
        s = upd_cnt;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (upd_cnt - s >= n) return;
        end
        tests++;
        fails++;
        $display("FAIL run_timeout: got %0d updates expected %0d", upd_cnt - s, n);
    endtask

    initial begin
        int n, ios;
        bit seen;
        vt[0] = '{8'd2,  8'h00, 8'h00, 0, 2,  8'd1, 8'h00, 1'b0};
        vt[1] = '{8'd1,  8'h00, 8'h00, 0, 2,  8'd1, 8'h00, 1'b0};
        vt[2] = '{8'd0,  8'h00, 8'h00, 0, 2,  8'd1, 8'h00, 1'b0};
        vt[3] = '{8'd3,  8'h00, 8'h40, 0, 2,  8'd1, 8'h40, 1'b1};
        vt[4] = '{8'd3,  8'h00, 8'h90, 0, 2,  8'd2, 8'h90, 1'b1};
        vt[5] = '{8'd10, 8'h03, 8'h00, 0, 3,  8'd1, 8'h03, 1'b0};
        vt[6] = '{8'd10, 8'hC8, 8'h00, 0, 3,  8'd2, 8'hC8, 1'b0};
        vt[7] = '{8'd10, 8'h03, 8'h00, 4, 15, 8'd1, 8'h03, 1'b0};
        vt[8] = '{8'd2,  8'h00, 8'h00, 2, 4,  8'd1, 8'h00, 1'b0};
        do_reset();
        chk("rst_outputs", 32'({mem_req, mem_we, mem_addr, mem_wdata, io_valid, update, halted}), 32'h0);
        chk("rst_io_out", 32'(io_out), 32'h0);
        chk("rst_retired", 32'(retired), 32'h0);
        for (int k = 0; k < 9; k++) begin
            do_reset();
            mem[0] = vt[k].a;
            if (vt[k].a >= 4) mem[vt[k].a] = vt[k].mval;
            io_in = vt[k].io;
            wait_n = vt[k].wt;
            start = 1;
            n = 0;
            do begin
                cyc();
                start = 0;
                n++;
            end while (!update && n < 60);
            chk($sformatf("v%0d_latency", k), 32'(n - 1), 32'(vt[k].lat));
            chk($sformatf("v%0d_next_pc", k), 32'(mem_addr), 32'(vt[k].npc));
            chk($sformatf("v%0d_io_valid", k), 32'(io_valid), 32'(vt[k].io_ev));
            if (vt[k].io_ev) chk($sformatf("v%0d_io_out", k), 32'(io_out), 32'(vt[k].res));
            if (vt[k].a >= 4) chk($sformatf("v%0d_mem_write", k), 32'(mem[vt[k].a]), 32'(vt[k].res));
            cyc();
            chk($sformatf("v%0d_update_single", k), 32'(update), 32'h0);
        end
        for (int wt = 0; wt <= 4; wt += 4) begin
            do_reset();
            wait_n = wt;
            mem[0] = 8'd11; mem[11] = 8'd5; mem[1] = 8'd10; mem[10] = 8'd3;
            go();
            run_upd(2, 80);
            chk("borrow_mem10", 32'(mem[10]), 32'hFE);
            chk("borrow_skip_pc", 32'(mem_addr), 32'd3);
            chk("borrow_retired", 32'(retired), 32'd2);
        end
        do_reset();
        mem[0] = 8'd11; mem[11] = 8'h10; mem[1] = 8'd3;
        io_in = 8'h40;
        go();
        run_upd(1, 20);
        ios = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            if (io_valid) ios++;
            seen = update;
        end
        chk("io_with_update", 32'({update, io_valid}), 32'h3);
        chk("io_out_val", 32'(io_out), 32'h30);
        chk("io_next_pc", 32'(mem_addr), 32'd2);
        cyc();
        chk("io_valid_pulses", 32'(ios + int'(io_valid)), 32'd1);
        do_reset();
        for (int i = 0; i < 5; i++) mem[i] = 8'd2;
        mem[5] = 8'd20; mem[20] = 8'd2; mem[6] = 8'd0;
        go();
        run_upd(7, 60);
        chk("jump_pc_from_r", 32'(mem_addr), 32'd5);
        run_upd(1, 20);
        chk("jump_then_mem", 32'(mem[20]), 32'hFE);
        chk("jump_then_pc", 32'(mem_addr), 32'd7);
        do_reset();
        mem[0] = 8'd20; mem[20] = 8'h80; mem[2] = 8'd0;
        go();
        run_upd(2, 30);
        chk("jump_borrow_pc", 32'(mem_addr), 32'h84);
        do_reset();
        mem[0] = 8'd10; mem[10] = 8'd4; mem[1] = 8'd0;
        go();
        run_upd(2, 30);
        cyc();
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_no_req", 32'(mem_req), 32'h0);
        chk("halt_retired", 32'(retired), 32'd2);
        go();
        chk("restart_flag", 32'(halted), 32'h0);
        chk("restart_fetch", 32'({mem_req, mem_addr}), 32'({1'b1, 8'h00}));
        run_upd(1, 20);
        chk("restart_next_pc", 32'(mem_addr), 32'd1);
        do_reset();
        wait_n = 4;
        mem[0] = 8'd3; mem[1] = 8'd10; mem[10] = 8'd7;
        io_in = 8'h55;
        go();
        n = 0;
        while (!(mem_req && mem_we) && n < 100) begin
            cyc();
            n++;
        end
        chk("reach_write", 32'({mem_req, mem_we}), 32'h3);
        cyc();
        chk("pre_reset_io", 32'(io_out), 32'h55);
        #1 reset = 1;
        #1;
        chk("midrst_req", 32'(mem_req), 32'h0);
        chk("midrst_outputs", 32'({mem_we, mem_addr, mem_wdata, io_valid, update, halted}), 32'h0);
        chk("midrst_io_retired", 32'({io_out, retired}), 32'h0);
        for (int run = 0; run < 25; run++) begin
            do_reset();
            for (int i = 0; i < 256; i++)
                mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 255));
            io_in = 8'($urandom);
            rand_wait = 1;
            m_mem = mem;
            m_pc = '0;
            m_acc = '0;
            m_halt = 0;
            model_on = 1;
            go();
            for (int i = 0; i < 300 && !halted; i++) cyc();
            if (halted) begin
                if (exp_q.size() == 0) model_step();
                chk("rand_halt", 32'({m_halt, exp_q.size() == 0}), 32'h3);
            end
            model_on = 0;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
